mem_image_loader: RTL and testbench
===================================

Name: mem_image_loader

Overview:
- Boot-time loader upstream of the instruction and data BRAM write ports.
- Consumes one 32-bit valid/ready word stream (from a host or UART bridge) in this order: header, instruction words, data words, checksum trailer.
- Writes instruction words into instruction BRAM and data words into data BRAM.
- Holds the CPU stalled until the image is verified, then releases it. In the top level, init_done replaces the hand-driven init-done/stall sequencing.

Parameters:
- ADDR_WIDTH, 10, BRAM byte-address width.
- DATA_WIDTH, 32, word width.
- I_BASE, 0, byte address of the first instruction word.
- D_BASE, 0, byte address of the first data word.
- MAX_WORDS, 256, per-segment word limit (2^ADDR_WIDTH/4).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a load; one-cycle pulse
- s_valid  in  1  stream word valid
- s_data  in  32  stream word
- s_ready  out  1  loader accepts s_data this cycle
- i_w_addr  out  10  instruction BRAM write byte address
- i_w_dat  out  32  instruction BRAM write data
- i_w_enb  out  1  instruction BRAM write enable
- d_w_addr  out  10  data BRAM write byte address
- d_w_dat  out  32  data BRAM write data
- d_w_enb  out  1  data BRAM write enable
- busy  out  1  load in progress
- init_done  out  1  image loaded and checksum verified
- cpu_stall  out  1  drives the PC stall input
- error  out  1  load aborted
- words_loaded  out  16  payload words written in the current load

Behaviour:
- Reset (rst=0, asynchronous):
  - State is IDLE.
  - All outputs are 0 except cpu_stall=1.
  - Counters and running sum are cleared.
- Handshake: a word transfers on a rising edge where s_valid and s_ready are both 1.
  - s_ready=1 only in HDR, INSTR, DATA and CSUM.
  - s_ready is a registered output.
  - Throughput is one word per cycle.
- States:
  - IDLE: start moves to HDR. Also clears error, init_done, words_loaded and sum, and sets cpu_stall=1 and busy=1.
  - HDR: header word layout is [31:16]=D_CNT, [15:0]=I_CNT.
    - Either count > MAX_WORDS goes to ERR.
    - Otherwise the next state is INSTR if I_CNT>0, else DATA if D_CNT>0, else CSUM.
    - sum is set to the header value.
  - INSTR: each accepted word is written to instruction BRAM at I_BASE+4*k, k = 0..I_CNT-1.
    - After the last word, go to DATA if D_CNT>0, else CSUM.
  - DATA: same as INSTR, targeting data BRAM at D_BASE+4*k.
    - After the last word, go to CSUM.
  - CSUM: accept one word.
    - If it equals sum (the mod-2^32 sum of header and all payload words), go to DONE. Otherwise go to ERR.
  - DONE: busy=0, init_done=1, cpu_stall=0.
    - start restarts the load as from IDLE, i.e. a reload with the CPU stalled again.
  - ERR: error=1, busy=0, cpu_stall=1, init_done=0.
    - Only start (restart as from IDLE) or reset leaves ERR.
- Write timing: write port outputs are registered.
  - A word accepted at edge N gives w_enb=1 with its addr/dat during cycle N+1; the BRAM commits at edge N+1.
  - w_enb is a single-cycle pulse per word.
  - i_w_enb and d_w_enb are never both 1.
- Address arithmetic: addresses are computed in ADDR_WIDTH bits.
  - A base + offset overflow wraps modulo 2^ADDR_WIDTH. This is legal but unchecked.
- words_loaded increments one cycle after each payload handshake. It holds its value in DONE and ERR.
- s_valid dropping mid-segment stalls the loader in its current state with no timeout. Counters hold.
- start while busy is ignored.
- Reset mid-load aborts immediately. Already-written BRAM words are not rolled back.

Test Plan:
- Nominal load: header 0x0002_0003, instr {0x00500293, 0x00300313, 0x0062A623}, data {0x11, 0x22}, trailer = sum → instr BRAM 0x0/0x4/0x8 and data BRAM 0x0/0x4 hold those words; words_loaded=5; init_done=1 and cpu_stall=0 one cycle after the trailer handshake.
- Bad checksum: same image, trailer = sum+1 → error=1, init_done=0, cpu_stall=1, s_ready=0; a subsequent start plus a correct image reaches DONE.
- Header 0x0000_0000 followed by trailer 0x00000000 → DONE with no BRAM writes and words_loaded=0.
- Oversize header 0x0000_0101 (I_CNT=257) → ERR immediately after the header; no write enables asserted.
- Bubbles: toggle s_valid every other cycle during INSTR → correct addresses and data, exactly one w_enb pulse per word, state held during gaps.
- Reset mid-INSTR after 2 words: rst low → all outputs return to reset values asynchronously; cpu_stall=1; first 2 instruction words remain in BRAM.

Source files
------------

// File: rtl/mem_image_loader.sv
// mem_image_loader
//   Boot-time image loader sitting in front of the instruction and data BRAM
//   write ports. It consumes one valid/ready word stream laid out as
//   header, instruction words, data words, checksum trailer. It writes the
//   payload into the two BRAMs and keeps the CPU stalled until the trailer
//   matches the running mod-2^32 sum of the header and all payload words.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   start               one-cycle pulse; begins a load from IDLE/DONE/ERR
//   s_valid/s_data      stream word in
//   s_ready             registered; high in HDR, INSTR, DATA and CSUM
//   i_w_addr/dat/enb    instruction BRAM write port (registered, byte address)
//   d_w_addr/dat/enb    data BRAM write port (registered, byte address)
//   busy                load in progress
//   init_done           image loaded and checksum verified
//   cpu_stall           PC stall; low only after a verified image
//   error               load aborted (oversize header or bad checksum)
//   words_loaded        payload words written in the current load
module mem_image_loader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned I_BASE     = 0,
  parameter int unsigned D_BASE     = 0,
  parameter int unsigned MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [DATA_WIDTH-1:0] i_w_dat,
  output logic                  i_w_enb,
  output logic [ADDR_WIDTH-1:0] d_w_addr,
  output logic [DATA_WIDTH-1:0] d_w_dat,
  output logic                  d_w_enb,
  output logic                  busy,
  output logic                  init_done,
  output logic                  cpu_stall,
  output logic                  error,
  output logic [15:0]           words_loaded
);

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StInstr,
    StData,
    StCsum,
    StDone,
    StErr
  } state_e;

  localparam logic [15:0]           LP_MAX    = 16'(MAX_WORDS);
  localparam logic [ADDR_WIDTH-1:0] LP_I_BASE = ADDR_WIDTH'(I_BASE);
  localparam logic [ADDR_WIDTH-1:0] LP_D_BASE = ADDR_WIDTH'(D_BASE);

  state_e                r_state, w_state_nxt;
  logic                  r_s_ready, w_s_ready_nxt;
  logic [15:0]           r_i_cnt, w_i_cnt_nxt;
  logic [15:0]           r_d_cnt, w_d_cnt_nxt;
  logic [15:0]           r_k, w_k_nxt;
  logic [DATA_WIDTH-1:0] r_sum, w_sum_nxt;
  logic [15:0]           r_words, w_words_nxt;
  logic [ADDR_WIDTH-1:0] r_i_w_addr, w_i_w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_i_w_dat, w_i_w_dat_nxt;
  logic                  r_i_w_enb, w_i_w_enb_nxt;
  logic [ADDR_WIDTH-1:0] r_d_w_addr, w_d_w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_d_w_dat, w_d_w_dat_nxt;
  logic                  r_d_w_enb, w_d_w_enb_nxt;

  logic                  w_hs;
  logic [15:0]           w_hdr_i, w_hdr_d;
  logic [15:0]           w_k_inc;
  logic [ADDR_WIDTH-1:0] w_off;

  assign w_hs    = s_valid & r_s_ready;
  assign w_hdr_i = s_data[15:0];
  assign w_hdr_d = s_data[31:16];
  assign w_k_inc = r_k + 16'd1;
  // Byte offset of word k; wraps silently in ADDR_WIDTH bits.
  assign w_off   = {r_k[ADDR_WIDTH-3:0], 2'b00};

  always_comb begin
    w_state_nxt    = r_state;
    w_i_cnt_nxt    = r_i_cnt;
    w_d_cnt_nxt    = r_d_cnt;
    w_k_nxt        = r_k;
    w_sum_nxt      = r_sum;
    w_words_nxt    = r_words;
    w_i_w_addr_nxt = r_i_w_addr;
    w_i_w_dat_nxt  = r_i_w_dat;
    w_i_w_enb_nxt  = 1'b0;
    w_d_w_addr_nxt = r_d_w_addr;
    w_d_w_dat_nxt  = r_d_w_dat;
    w_d_w_enb_nxt  = 1'b0;

    unique case (r_state)
      StIdle, StDone, StErr: begin
        // start while busy never reaches here, so it is ignored for free.
        if (start) begin
          w_state_nxt = StHdr;
          w_k_nxt     = 16'd0;
          w_sum_nxt   = '0;
          w_words_nxt = 16'd0;
        end
      end
      StHdr: begin
        if (w_hs) begin
          w_sum_nxt   = s_data;
          w_i_cnt_nxt = w_hdr_i;
          w_d_cnt_nxt = w_hdr_d;
          w_k_nxt     = 16'd0;
          if (w_hdr_i > LP_MAX || w_hdr_d > LP_MAX) begin
            w_state_nxt = StErr;
          end else if (w_hdr_i != 16'd0) begin
            w_state_nxt = StInstr;
          end else if (w_hdr_d != 16'd0) begin
            w_state_nxt = StData;
          end else begin
            w_state_nxt = StCsum;
          end
        end
      end
      StInstr: begin
        if (w_hs) begin
          w_i_w_enb_nxt  = 1'b1;
          w_i_w_addr_nxt = LP_I_BASE + w_off;
          w_i_w_dat_nxt  = s_data;
          w_sum_nxt      = r_sum + s_data;
          w_words_nxt    = r_words + 16'd1;
          if (w_k_inc == r_i_cnt) begin
            w_k_nxt     = 16'd0;
            w_state_nxt = (r_d_cnt != 16'd0) ? StData : StCsum;
          end else begin
            w_k_nxt = w_k_inc;
          end
        end
      end
      StData: begin
        if (w_hs) begin
          w_d_w_enb_nxt  = 1'b1;
          w_d_w_addr_nxt = LP_D_BASE + w_off;
          w_d_w_dat_nxt  = s_data;
          w_sum_nxt      = r_sum + s_data;
          w_words_nxt    = r_words + 16'd1;
          if (w_k_inc == r_d_cnt) begin
            w_k_nxt     = 16'd0;
            w_state_nxt = StCsum;
          end else begin
            w_k_nxt = w_k_inc;
          end
        end
      end
      StCsum: begin
        if (w_hs) begin
          w_state_nxt = (s_data == r_sum) ? StDone : StErr;
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    // s_ready is registered: it follows the state being entered.
    w_s_ready_nxt = (w_state_nxt == StHdr) || (w_state_nxt == StInstr) ||
                    (w_state_nxt == StData) || (w_state_nxt == StCsum);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_s_ready  <= 1'b0;
      r_i_cnt    <= 16'd0;
      r_d_cnt    <= 16'd0;
      r_k        <= 16'd0;
      r_sum      <= '0;
      r_words    <= 16'd0;
      r_i_w_addr <= '0;
      r_i_w_dat  <= '0;
      r_i_w_enb  <= 1'b0;
      r_d_w_addr <= '0;
      r_d_w_dat  <= '0;
      r_d_w_enb  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_s_ready  <= w_s_ready_nxt;
      r_i_cnt    <= w_i_cnt_nxt;
      r_d_cnt    <= w_d_cnt_nxt;
      r_k        <= w_k_nxt;
      r_sum      <= w_sum_nxt;
      r_words    <= w_words_nxt;
      r_i_w_addr <= w_i_w_addr_nxt;
      r_i_w_dat  <= w_i_w_dat_nxt;
      r_i_w_enb  <= w_i_w_enb_nxt;
      r_d_w_addr <= w_d_w_addr_nxt;
      r_d_w_dat  <= w_d_w_dat_nxt;
      r_d_w_enb  <= w_d_w_enb_nxt;
    end
  end

  assign s_ready      = r_s_ready;
  assign i_w_addr     = r_i_w_addr;
  assign i_w_dat      = r_i_w_dat;
  assign i_w_enb      = r_i_w_enb;
  assign d_w_addr     = r_d_w_addr;
  assign d_w_dat      = r_d_w_dat;
  assign d_w_enb      = r_d_w_enb;
  assign words_loaded = r_words;

  // Status is a pure decode of the state register, so reset reaches it
  // asynchronously along with the state.
  assign busy      = (r_state == StHdr) || (r_state == StInstr) ||
                     (r_state == StData) || (r_state == StCsum);
  assign init_done = (r_state == StDone);
  assign error     = (r_state == StErr);
  assign cpu_stall = (r_state != StDone);

endmodule

// File: tb/tb_mem_image_loader.sv
// tb_mem_image_loader
//   Self-checking bench for mem_image_loader. A BRAM model captures every
//   write pulse; expected images, checksums and counts are built in the bench.
module tb_mem_image_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic [9:0]  i_w_addr;
  logic [31:0] i_w_dat;
  logic        i_w_enb;
  logic [9:0]  d_w_addr;
  logic [31:0] d_w_dat;
  logic        d_w_enb;
  logic        busy;
  logic        init_done;
  logic        cpu_stall;
  logic        error;
  logic [15:0] words_loaded;

  int errors = 0;
  int checks = 0;

  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  logic [31:0] img_i [256];
  logic [31:0] img_d [256];
  int          i_wr, d_wr, both_wr;

  mem_image_loader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .i_w_addr    (i_w_addr),
    .i_w_dat     (i_w_dat),
    .i_w_enb     (i_w_enb),
    .d_w_addr    (d_w_addr),
    .d_w_dat     (d_w_dat),
    .d_w_enb     (d_w_enb),
    .busy        (busy),
    .init_done   (init_done),
    .cpu_stall   (cpu_stall),
    .error       (error),
    .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: each enable high for a cycle commits one word.
  always @(negedge clk) begin
    if (i_w_enb) begin imem[i_w_addr[9:2]] = i_w_dat; i_wr++; end
    if (d_w_enb) begin dmem[d_w_addr[9:2]] = d_w_dat; d_wr++; end
    if (i_w_enb && d_w_enb) both_wr++;
  end

  task automatic clear_model();
    for (int i = 0; i < 256; i++) begin
      imem[i] = 32'hDEAD_BEEF;
      dmem[i] = 32'hDEAD_BEEF;
    end
    i_wr = 0; d_wr = 0; both_wr = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called on a falling edge; returns on the falling edge after the transfer.
  task automatic send(input logic [31:0] w);
    int t;
    t = 0;
    s_valid = 1'b1;
    s_data  = w;
    while (s_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    checks++;
    if (t >= 50) begin
      errors++;
      $display("FAIL send_timeout word=%h s_ready got %b want 1", w, s_ready);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic load_image(input int ic, input int dc, input bit bad, input int gap_pct);
    logic [31:0] hdr, sum;
    hdr = {16'(dc), 16'(ic)};
    sum = hdr;
    pulse_start();
    send(hdr);
    for (int i = 0; i < ic; i++) begin
      if ($urandom_range(99) < gap_pct) @(negedge clk);
      send(img_i[i]);
      sum = sum + img_i[i];
    end
    for (int i = 0; i < dc; i++) begin
      if ($urandom_range(99) < gap_pct) @(negedge clk);
      send(img_d[i]);
      sum = sum + img_d[i];
    end
    send(bad ? sum + 32'd1 : sum);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset s_ready got %b want 0", s_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", busy); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset init_done got %b want 0", init_done); end
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL reset cpu_stall got %b want 1", cpu_stall); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset error got %b want 0", error); end
    checks++; if (words_loaded !== 16'd0) begin errors++; $display("FAIL reset words_loaded got %0d want 0", words_loaded); end
    checks++; if (i_w_enb !== 1'b0 || d_w_enb !== 1'b0) begin errors++; $display("FAIL reset w_enb got %b%b want 00", i_w_enb, d_w_enb); end
  endtask

  task automatic set_nominal_image();
    img_i[0] = 32'h0050_0293; img_i[1] = 32'h0030_0313; img_i[2] = 32'h0062_A623;
    img_d[0] = 32'h0000_0011; img_d[1] = 32'h0000_0022;
  endtask

  task automatic test_nominal();
    set_nominal_image();
    clear_model();
    load_image(3, 2, 1'b0, 0);
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL nominal init_done got %b want 1", init_done); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL nominal cpu_stall got %b want 0", cpu_stall); end
    checks++; if (busy !== 1'b0 || s_ready !== 1'b0) begin errors++; $display("FAIL nominal busy/s_ready got %b%b want 00", busy, s_ready); end
    settle();
    checks++; if (words_loaded !== 16'd5) begin errors++; $display("FAIL nominal words_loaded got %0d want 5", words_loaded); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem[i] !== img_i[i]) begin errors++; $display("FAIL nominal imem[%0d] got %h want %h", i, imem[i], img_i[i]); end
    end
    for (int i = 0; i < 2; i++) begin
      checks++; if (dmem[i] !== img_d[i]) begin errors++; $display("FAIL nominal dmem[%0d] got %h want %h", i, dmem[i], img_d[i]); end
    end
    checks++; if (i_wr != 3 || d_wr != 2 || both_wr != 0) begin errors++; $display("FAIL nominal write_count got i=%0d d=%0d both=%0d want 3 2 0", i_wr, d_wr, both_wr); end
  endtask

  task automatic test_bad_csum();
    set_nominal_image();
    clear_model();
    load_image(3, 2, 1'b1, 0);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL bad_csum error got %b want 1", error); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL bad_csum init_done got %b want 0", init_done); end
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL bad_csum cpu_stall got %b want 1", cpu_stall); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bad_csum s_ready got %b want 0", s_ready); end
    repeat (3) @(negedge clk);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL bad_csum error_hold got %b want 1", error); end
    clear_model();
    load_image(3, 2, 1'b0, 0);
    checks++; if (init_done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL bad_csum_retry done/err got %b%b want 10", init_done, error); end
    settle();
    checks++; if (imem[2] !== img_i[2]) begin errors++; $display("FAIL bad_csum_retry imem[2] got %h want %h", imem[2], img_i[2]); end
  endtask

  task automatic test_empty();
    clear_model();
    // Previous load ended in DONE: start must stall the CPU again.
    pulse_start();
    checks++; if (cpu_stall !== 1'b1 || init_done !== 1'b0) begin errors++; $display("FAIL restart stall/done got %b%b want 10", cpu_stall, init_done); end
    checks++; if (busy !== 1'b1 || s_ready !== 1'b1) begin errors++; $display("FAIL restart busy/s_ready got %b%b want 11", busy, s_ready); end
    checks++; if (words_loaded !== 16'd0) begin errors++; $display("FAIL restart words_loaded got %0d want 0", words_loaded); end
    send(32'h0000_0000);
    send(32'h0000_0000);
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL empty init_done got %b want 1", init_done); end
    settle();
    checks++; if (i_wr != 0 || d_wr != 0) begin errors++; $display("FAIL empty writes got i=%0d d=%0d want 0 0", i_wr, d_wr); end
    checks++; if (words_loaded !== 16'd0) begin errors++; $display("FAIL empty words_loaded got %0d want 0", words_loaded); end
  endtask

  task automatic test_oversize();
    clear_model();
    pulse_start();
    send(32'h0000_0101);
    checks++; if (error !== 1'b1 || s_ready !== 1'b0) begin errors++; $display("FAIL oversize_i err/s_ready got %b%b want 10", error, s_ready); end
    s_valid = 1'b1; s_data = 32'h1234_5678;
    repeat (4) @(negedge clk);
    s_valid = 1'b0;
    checks++; if (i_wr != 0 || d_wr != 0) begin errors++; $display("FAIL oversize_i writes got i=%0d d=%0d want 0 0", i_wr, d_wr); end
    pulse_start();
    send(32'h0101_0000);
    checks++; if (error !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL oversize_d err/busy got %b%b want 10", error, busy); end
    settle();
    checks++; if (i_wr != 0 || d_wr != 0) begin errors++; $display("FAIL oversize_d writes got i=%0d d=%0d want 0 0", i_wr, d_wr); end
  endtask

  task automatic test_max_segment();
    for (int i = 0; i < 256; i++) img_i[i] = $urandom;
    clear_model();
    load_image(256, 0, 1'b0, 0);
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL max init_done got %b want 1", init_done); end
    settle();
    checks++; if (words_loaded !== 16'd256) begin errors++; $display("FAIL max words_loaded got %0d want 256", words_loaded); end
    checks++; if (imem[0] !== img_i[0] || imem[255] !== img_i[255]) begin errors++; $display("FAIL max imem ends got %h %h want %h %h", imem[0], imem[255], img_i[0], img_i[255]); end
  endtask

  task automatic test_bubbles();
    logic [31:0] sum;
    for (int i = 0; i < 4; i++) img_i[i] = $urandom;
    clear_model();
    pulse_start();
    sum = 32'h0000_0004;
    send(sum);
    for (int k = 0; k < 4; k++) begin
      send(img_i[k]);
      sum = sum + img_i[k];
      checks++; if (i_w_enb !== 1'b1 || d_w_enb !== 1'b0) begin errors++; $display("FAIL bubble enb k=%0d got %b%b want 10", k, i_w_enb, d_w_enb); end
      checks++; if (i_w_addr !== 10'(4 * k)) begin errors++; $display("FAIL bubble addr k=%0d got %h want %h", k, i_w_addr, 10'(4 * k)); end
      checks++; if (i_w_dat !== img_i[k]) begin errors++; $display("FAIL bubble dat k=%0d got %h want %h", k, i_w_dat, img_i[k]); end
      // Gap cycle; a start pulse here must be ignored.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++; if (i_w_enb !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL bubble gap enb/rdy/busy got %b%b%b want 011", i_w_enb, s_ready, busy); end
      checks++; if (words_loaded !== 16'(k + 1)) begin errors++; $display("FAIL bubble words k=%0d got %0d want %0d", k, words_loaded, k + 1); end
    end
    send(sum);
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL bubble init_done got %b want 1", init_done); end
    settle();
    checks++; if (i_wr != 4) begin errors++; $display("FAIL bubble pulses got %0d want 4", i_wr); end
  endtask

  task automatic test_reset_mid();
    img_i[0] = $urandom; img_i[1] = $urandom;
    clear_model();
    pulse_start();
    send(32'h0000_0003);
    send(img_i[0]);
    send(img_i[1]);
    #2 rst = 1'b0;
    #1;
    checks++; if (s_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid rdy/busy got %b%b want 00", s_ready, busy); end
    checks++; if (cpu_stall !== 1'b1 || init_done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL rstmid stall/done/err got %b%b%b want 100", cpu_stall, init_done, error); end
    checks++; if (i_w_enb !== 1'b0 || words_loaded !== 16'd0) begin errors++; $display("FAIL rstmid enb/words got %b %0d want 0 0", i_w_enb, words_loaded); end
    checks++; if (imem[0] !== img_i[0] || imem[1] !== img_i[1]) begin errors++; $display("FAIL rstmid kept got %h %h want %h %h", imem[0], imem[1], img_i[0], img_i[1]); end
    checks++; if (i_wr != 2) begin errors++; $display("FAIL rstmid writes got %0d want 2", i_wr); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    int  ic, dc;
    bit  bad;
    for (int it = 0; it < 6; it++) begin
      ic  = $urandom_range(12);
      dc  = $urandom_range(12);
      bad = ($urandom_range(3) == 0);
      for (int i = 0; i < ic; i++) img_i[i] = $urandom;
      for (int i = 0; i < dc; i++) img_d[i] = $urandom;
      clear_model();
      load_image(ic, dc, bad, 30);
      checks++;
      if (init_done !== !bad || error !== bad || cpu_stall !== bad) begin
        errors++;
        $display("FAIL random%0d done/err/stall got %b%b%b want %b%b%b", it, init_done, error, cpu_stall, !bad, bad, bad);
      end
      settle();
      checks++; if (words_loaded !== 16'(ic + dc)) begin errors++; $display("FAIL random%0d words got %0d want %0d", it, words_loaded, ic + dc); end
      checks++; if (i_wr != ic || d_wr != dc || both_wr != 0) begin errors++; $display("FAIL random%0d pulses got %0d %0d %0d want %0d %0d 0", it, i_wr, d_wr, both_wr, ic, dc); end
      for (int i = 0; i < ic; i++) begin
        checks++; if (imem[i] !== img_i[i]) begin errors++; $display("FAIL random%0d imem[%0d] got %h want %h", it, i, imem[i], img_i[i]); end
      end
      for (int i = 0; i < dc; i++) begin
        checks++; if (dmem[i] !== img_d[i]) begin errors++; $display("FAIL random%0d dmem[%0d] got %h want %h", it, i, dmem[i], img_d[i]); end
      end
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 32'd0;
    clear_model();
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_nominal();
    test_bad_csum();
    test_empty();
    test_oversize();
    test_max_segment();
    test_bubbles();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
